// File: rtl/router_pkg.sv
// router_pkg: shared widths, tx state encoding and header framing helpers.
package router_pkg;
    localparam int ADDR_W = 2;
    localparam int LEN_W = 6;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, GAP} tx_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } hdr_t;

    function automatic logic [7:0] hdr_pack(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        return {len, addr};
    endfunction

    function automatic hdr_t hdr_unpack(input logic [7:0] b);
        return hdr_t'(b);
    endfunction
endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: single-clock payload RAM, synchronous write and write-first synchronous read.
module router_tx_buf #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       we_i,
    input  logic [5:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [5:0] raddr_i,
    output logic [7:0] rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // write-first so a 1-byte payload is readable on the edge that stores it
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= (we_i && waddr_i == raddr_i) ? wdata_i : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a host packet, then sends header, payload and parity to the router.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN = 63,
    parameter int IFG = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_inj_err,
    output logic       cmd_err,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic [7:0] pay_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       tx_active
);
    tx_state_e   state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [5:0]  len_q, len_d;
    logic        inj_q, inj_d;
    logic [7:0]  par_q, par_d;
    logic [5:0]  wr_idx_q, wr_idx_d;
    logic [5:0]  rd_idx_q, rd_idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        pkt_valid_q, pkt_valid_d;
    logic        cmd_err_q, cmd_err_d;
    logic        tx_done_q, tx_done_d;
    logic        consume, buf_we;
    logic [5:0]  buf_raddr;
    logic [7:0]  buf_rdata;

    assign consume = !busy && (state_q == HDR || state_q == PAY || state_q == PAR);
    assign buf_we = state_q == LOAD && pay_valid;
    // rd_idx_q names the byte already sitting in the RAM output; fetch the following one on consumption
    assign buf_raddr = (consume && state_q != PAR) ? rd_idx_q + 6'd1 : rd_idx_q;

    router_tx_buf #(.DEPTH(MAX_LEN + 1)) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (wr_idx_q),
        .wdata_i (pay_data),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        len_d = len_q;
        inj_d = inj_q;
        par_d = par_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        gap_d = gap_q;
        data_out_d = data_out_q;
        pkt_valid_d = pkt_valid_q;
        cmd_err_d = 1'b0;
        tx_done_d = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (cmd_addr == ADDR_INVALID || cmd_len == '0) begin
                    cmd_err_d = 1'b1;
                end else begin
                    addr_d = cmd_addr;
                    len_d = cmd_len;
                    inj_d = cmd_inj_err;
                    par_d = hdr_pack(cmd_addr, cmd_len);
                    wr_idx_d = '0;
                    rd_idx_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: if (pay_valid) begin
                par_d = par_q ^ pay_data;
                wr_idx_d = wr_idx_q + 6'd1;
                if (wr_idx_q == len_q - 6'd1) begin
                    state_d = HDR;
                    data_out_d = hdr_pack(addr_q, len_q);
                    pkt_valid_d = 1'b1;
                end
            end
            HDR: if (consume) begin
                data_out_d = buf_rdata;
                rd_idx_d = rd_idx_q + 6'd1;
                state_d = PAY;
            end
            PAY: if (consume) begin
                if (rd_idx_q == len_q) begin
                    state_d = PAR;
                    pkt_valid_d = 1'b0;
                    data_out_d = par_q ^ {7'b0, inj_q};
                end else begin
                    data_out_d = buf_rdata;
                    rd_idx_d = rd_idx_q + 6'd1;
                end
            end
            PAR: if (consume) begin
                tx_done_d = 1'b1;
                data_out_d = '0;
                gap_d = 4'(IFG);
                state_d = GAP;
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            len_q <= '0;
            inj_q <= 1'b0;
            par_q <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            gap_q <= '0;
            data_out_q <= '0;
            pkt_valid_q <= 1'b0;
            cmd_err_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            len_q <= len_d;
            inj_q <= inj_d;
            par_q <= par_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            gap_q <= gap_d;
            data_out_q <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            cmd_err_q <= cmd_err_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign pay_ready = state_q == LOAD;
    assign tx_active = state_q != IDLE;
    assign pkt_valid = pkt_valid_q;
    assign data_out = data_out_q;
    assign cmd_err = cmd_err_q;
    assign tx_done = tx_done_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed packets; expected bytes queued by stimulus, checked by a monitor.
module tb_router_pkt_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic       cmd_inj_err = 1'b0;
    logic       cmd_err;
    logic       pay_valid = 1'b0;
    logic       pay_ready;
    logic [7:0] pay_data = '0;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       tx_active;

    typedef struct packed {
        logic       par;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pl[$];
    int         total = 0;
    int         bad = 0;

    router_pkt_tx #(.MAX_LEN(63), .IFG(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_inj_err (cmd_inj_err),
        .cmd_err     (cmd_err),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_data    (pay_data),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .tx_done     (tx_done),
        .tx_active   (tx_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // monitor: bytes consumed with pkt_valid, and the parity byte on the cycle before tx_done
    initial begin
        exp_t e;
        logic prev_pv;
        logic [7:0] prev_d;
        int falls;
        prev_pv = 1'b0;
        prev_d = '0;
        falls = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_pv = 1'b0;
                prev_d = '0;
                falls = 0;
            end else begin
                if (pkt_valid && !busy) begin
                    if (exp_q.size() == 0) fail("unexpected_byte");
                    else begin
                        e = exp_q.pop_front();
                        chk("byte_kind", 32'(e.par), 32'(0));
                        chk("byte", 32'(data_out), 32'(e.d));
                    end
                end
                if (prev_pv && !pkt_valid) falls++;
                if (tx_done) begin
                    if (exp_q.size() == 0) fail("unexpected_parity");
                    else begin
                        e = exp_q.pop_front();
                        chk("parity_kind", 32'(e.par), 32'(1));
                        chk("parity", 32'(prev_d), 32'(e.d));
                        chk("pkt_valid_drops", 32'(falls), 32'(1));
                    end
                    falls = 0;
                end
                prev_pv = pkt_valid;
                prev_d = data_out;
            end
        end
    end

    task automatic load(input logic [1:0] a, input logic [5:0] l, input logic inj, input logic [7:0] par);
        int n;
        int i;
        logic ok;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) fail("cmd_ready_timeout");
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_len = l;
        cmd_inj_err = inj;
        exp_q.push_back({1'b0, l, a});
        foreach (pl[k]) exp_q.push_back({1'b0, pl[k]});
        exp_q.push_back({1'b1, par});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_inj_err = 1'b0;
        i = 0;
        n = 0;
        while (i < int'(l) && n < 500) begin
            pay_valid = 1'b1;
            pay_data = pl[i];
            @(negedge clk);
            ok = pay_ready;
            @(posedge clk); #1;
            if (ok) i++;
            n++;
        end
        if (n == 500) fail("payload_timeout");
        pay_valid = 1'b0;
    endtask

    task automatic finish_pkt(input int stall, input logic [7:0] stall_b, input int exp_hold, input int exp_pv);
        int n, left, hold, pv;
        bit seen, got;
        n = 0; left = 0; hold = 0; pv = 0; seen = 0; got = 0;
        while (!got && n < 1000) begin
            if (tx_done) got = 1;
            else begin
                if (pkt_valid) pv++;
                if (stall != 0 && pkt_valid && data_out == stall_b) hold++;
                if (stall != 0 && !seen && pkt_valid && data_out == stall_b) begin
                    seen = 1;
                    left = 3;
                end
                busy = left > 0;
                if (left > 0) left--;
                @(posedge clk); #1;
                n++;
            end
        end
        busy = 1'b0;
        if (!got) fail("tx_done_timeout");
        else begin
            if (stall != 0) chk("stall_hold", 32'(hold), 32'(exp_hold));
            chk("pkt_valid_cycles", 32'(pv), 32'(exp_pv));
            chk("gap1_cmd_ready", 32'(cmd_ready), 32'(0));
            chk("gap1_data", 32'(data_out), 32'(0));
            chk("gap1_pkt_valid", 32'(pkt_valid), 32'(0));
            @(posedge clk); #1;
            chk("tx_done_pulse", 32'(tx_done), 32'(0));
            chk("gap2_cmd_ready", 32'(cmd_ready), 32'(0));
            chk("gap2_data", 32'(data_out), 32'(0));
            @(posedge clk); #1;
            chk("ifg_cmd_ready", 32'(cmd_ready), 32'(1));
        end
    endtask

    task automatic bad_cmd(input logic [1:0] a, input logic [5:0] l);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_len = l;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("cmd_err_pulse", 32'(cmd_err), 32'(1));
        chk("err_pay_ready", 32'(pay_ready), 32'(0));
        chk("err_pkt_valid", 32'(pkt_valid), 32'(0));
        chk("err_cmd_ready", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        chk("cmd_err_clear", 32'(cmd_err), 32'(0));
        chk("err_tx_active", 32'(tx_active), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pkt_valid", 32'(pkt_valid), 32'(0));
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_cmd_err", 32'(cmd_err), 32'(0));
        chk("rst_tx_done", 32'(tx_done), 32'(0));
        chk("rst_pay_ready", 32'(pay_ready), 32'(0));
        chk("rst_tx_active", 32'(tx_active), 32'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));

        pl = '{8'h11, 8'h22, 8'h33};
        load(2'd1, 6'd3, 1'b0, 8'h0D);
        finish_pkt(0, 8'h00, 0, 4);

        load(2'd1, 6'd3, 1'b0, 8'h0D);
        finish_pkt(1, 8'h22, 4, 7);

        bad_cmd(2'd3, 6'd5);
        bad_cmd(2'd0, 6'd0);

        pl.delete();
        for (int i = 0; i < 63; i++) pl.push_back(8'(i));
        load(2'd2, 6'd63, 1'b0, 8'hC1);
        finish_pkt(0, 8'h00, 0, 64);

        pl = '{8'hA5};
        load(2'd0, 6'd1, 1'b1, 8'hA0);
        finish_pkt(0, 8'h00, 0, 2);

        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        load(2'd1, 6'd4, 1'b0, 8'h15);
        n = 0;
        while (!(pkt_valid && data_out == 8'h02) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) fail("reach_byte2_timeout");
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("midrst_pkt_valid", 32'(pkt_valid), 32'(0));
        chk("midrst_data_out", 32'(data_out), 32'(0));
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
        chk("midrst_tx_active", 32'(tx_active), 32'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        pl = '{8'h11, 8'h22, 8'h33};
        load(2'd1, 6'd3, 1'b0, 8'h0D);
        finish_pkt(0, 8'h00, 0, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
